// File: rtl/alu_arm_mc_if.sv
// Request/result bundle between the operand read stage and the multi-cycle ALU.
// master drives start/op/operands; slave returns out/wr/done/busy and NZCV.
interface alu_arm_mc_if #(
  parameter int W = 32
);
  logic         start;
  logic [3:0]   op;
  logic         mul;
  logic         acc;
  logic         s;
  logic         shc;
  logic [W-1:0] da;
  logic [W-1:0] db;
  logic [W-1:0] dc;
  logic [W-1:0] out;
  logic         wr;
  logic         done;
  logic         busy;
  logic         NF;
  logic         CF;
  logic         ZF;
  logic         VF;

  modport master (
    output start, op, mul, acc, s, shc, da, db, dc,
    input  out, wr, done, busy, NF, CF, ZF, VF
  );

  modport slave (
    input  start, op, mul, acc, s, shc, da, db, dc,
    output out, wr, done, busy, NF, CF, ZF, VF
  );
endinterface

// File: rtl/alu_arm_mc.sv
// ARM execute ALU: single-cycle DP ops, shift-add MUL/MLA, NZCV register.
// Ports: clk, rst_n (async low), alu (slave: start/op/operands in, out/wr/done/busy/flags out).
module alu_arm_mc #(
  parameter int W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_arm_mc_if.slave alu
);
  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t        st;
  logic [W-1:0]  mcand;
  logic [W-1:0]  mplr;
  logic [W-1:0]  accr;
  logic [CW-1:0] cnt;
  logic          ms;

  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         cin;
  logic         arith;
  logic [W-1:0] lres;
  logic [W:0]   sum;
  logic [W-1:0] res;
  logic         cres;
  logic         vres;
  logic         test;
  logic [W-1:0] mstep;

  // Subtractions reuse the adder as x + ~y + c, so C is "not borrow".
  always_comb begin
    x     = '0;
    y     = '0;
    cin   = 1'b0;
    arith = 1'b0;
    lres  = '0;
    unique case (alu.op)
      4'h0, 4'h8: lres = alu.da & alu.db;
      4'h1, 4'h9: lres = alu.da ^ alu.db;
      4'h2, 4'hA: begin
        arith = 1'b1; x = alu.da; y = ~alu.db; cin = 1'b1;
      end
      4'h3: begin
        arith = 1'b1; x = alu.db; y = ~alu.da; cin = 1'b1;
      end
      4'h4, 4'hB: begin
        arith = 1'b1; x = alu.da; y = alu.db;
      end
      4'h5: begin
        arith = 1'b1; x = alu.da; y = alu.db; cin = alu.CF;
      end
      4'h6: begin
        arith = 1'b1; x = alu.da; y = ~alu.db; cin = alu.CF;
      end
      4'h7: begin
        arith = 1'b1; x = alu.db; y = ~alu.da; cin = alu.CF;
      end
      4'hC: lres = alu.da | alu.db;
      4'hD: lres = alu.db;
      4'hE: lres = alu.da & ~alu.db;
      4'hF: lres = ~alu.db;
      default: lres = '0;
    endcase
  end

  assign sum   = {1'b0, x} + {1'b0, y} + (W+1)'(cin);
  assign res   = arith ? sum[W-1:0] : lres;
  assign cres  = arith ? sum[W] : alu.shc;
  assign vres  = arith ? ((x[W-1] == y[W-1]) && (sum[W-1] != x[W-1]))
                       : alu.VF;
  assign test  = (alu.op[3:2] == 2'b10);
  assign mstep = mplr[0] ? accr + mcand : accr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= S_IDLE;
      mcand    <= '0;
      mplr     <= '0;
      accr     <= '0;
      cnt      <= '0;
      ms       <= 1'b0;
      alu.out  <= '0;
      alu.wr   <= 1'b0;
      alu.done <= 1'b0;
      alu.busy <= 1'b0;
      alu.NF   <= 1'b0;
      alu.CF   <= 1'b0;
      alu.ZF   <= 1'b0;
      alu.VF   <= 1'b0;
    end else begin
      alu.done <= 1'b0;
      unique case (st)
        S_IDLE: begin
          if (alu.start && alu.mul) begin
            mcand    <= alu.da;
            mplr     <= alu.db;
            accr     <= alu.acc ? alu.dc : '0;
            cnt      <= '0;
            ms       <= alu.s;
            alu.busy <= 1'b1;
            st       <= S_MUL;
          end else if (alu.start) begin
            alu.done <= 1'b1;
            alu.wr   <= !test;
            if (!test) alu.out <= res;
            if (alu.s || test) begin
              alu.NF <= res[W-1];
              alu.ZF <= (res == '0);
              alu.CF <= cres;
              alu.VF <= vres;
            end
          end
        end
        S_MUL: begin
          accr  <= mstep;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            alu.out  <= mstep;
            alu.wr   <= 1'b1;
            alu.done <= 1'b1;
            alu.busy <= 1'b0;
            st       <= S_IDLE;
            if (ms) begin
              alu.NF <= mstep[W-1];
              alu.ZF <= (mstep == '0);
            end
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end
endmodule
